spi_slv_frame: RTL

- SPI slave frame receiver that consumes o_sclk/o_csb/o_mosi from the SPI master generator and drives its i_miso.
- Oversamples SPI pins in the system clock domain and shifts 24-bit frames (cmd, data, CRC8), MSB first.
- Checks frame length and CRC, then issues a single-cycle register write or read.
- Presents the response frame on MISO during the next transaction, with daisy-chain pass-through of incoming bits.

---
 rtl/spi_slv_frame_pkg.sv | 26 ++
 rtl/spi_slv_frame_if.sv | 28 ++
 rtl/crc16to8_parallel.sv | 15 +
 rtl/spi_slv_frame_sync.sv | 43 ++++
 rtl/spi_slv_frame.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/spi_slv_frame_pkg.sv
// Shared definitions for the SPI slave frame receiver: frame layout, status
// bits and FSM states.
package spi_slv_pkg;

  localparam int FRAME_W = 24;

  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 8;
  localparam int CRC_MSB  = 7;
  localparam int CRC_LSB  = 0;

  localparam int ST_CRC_BIT = 7;
  localparam int ST_LEN_BIT = 6;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/spi_slv_frame_if.sv
// SPI pins plus the register-bus side of the frame receiver, seen from the
// slave (the receiver) or the master (pin driver / register file).
interface spi_slv_frame_if;
  logic       i_sclk;
  logic       i_csb;
  logic       i_mosi;
  logic       o_miso;
  logic       o_wr_en;
  logic       o_rd_en;
  logic [6:0] o_addr;
  logic [7:0] o_wdata;
  logic [7:0] i_rdata;
  logic       o_frm_done;
  logic       o_crc_err;
  logic       o_len_err;

  modport slave (
    input  i_sclk, i_csb, i_mosi, i_rdata,
    output o_miso, o_wr_en, o_rd_en, o_addr, o_wdata,
           o_frm_done, o_crc_err, o_len_err
  );

  modport master (
    output i_sclk, i_csb, i_mosi, i_rdata,
    input  o_miso, o_wr_en, o_rd_en, o_addr, o_wdata,
           o_frm_done, o_crc_err, o_len_err
  );
endinterface

// File: rtl/crc16to8_parallel.sv
// CRC-8 (poly 0x07, init 0x00, MSB first) over a 16-bit word in one cycle.
module crc16to8_parallel (
  input  logic [15:0] i_data,
  output logic [7:0]  o_crc
);
  localparam logic [7:0] POLY = 8'h07;

  always_comb begin
    o_crc = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (o_crc[7] ^ i_data[i]) o_crc = {o_crc[6:0], 1'b0} ^ POLY;
      else                      o_crc = {o_crc[6:0], 1'b0};
    end
  end
endmodule

// File: rtl/spi_slv_frame_sync.sv
// Brings the asynchronous SPI pins into the i_clk domain and produces
// single-cycle edge pulses for sclk and csb.
module spi_slv_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_csb,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_csb_rise,
  output logic o_csb_fall,
  output logic o_mosi_s
);
  logic [SYNC_STG-1:0] r_sclk_sync, r_csb_sync, r_mosi_sync;
  logic                r_sclk_d, r_csb_d;
  logic                w_sclk_s, w_csb_s;

  // csb resets low so a chip select already asserted at reset release is not taken as a start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_csb_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], i_sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STG-2:0], i_csb};
      r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_csb_d     <= w_csb_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STG-1];
  assign w_csb_s     = r_csb_sync[SYNC_STG-1];
  assign o_mosi_s    = r_mosi_sync[SYNC_STG-1];
  assign o_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign o_csb_rise  = w_csb_s & ~r_csb_d;
  assign o_csb_fall  = ~w_csb_s & r_csb_d;
endmodule

// File: rtl/spi_slv_frame.sv
// SPI slave frame receiver: shifts cmd/data/CRC8 frames, executes the last one
// received and returns its response on MISO during the next transaction.
module spi_slv_frame
  import spi_slv_pkg::*;
#(
  parameter int SYNC_STG  = 2,
  parameter int MAX_CHAIN = 4
) (
  input logic            i_clk,
  input logic            i_rst_n,
  spi_slv_frame_if.slave bus
);
  localparam int BCW = $clog2(FRAME_W);
  localparam int FCW = $clog2(MAX_CHAIN + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_W - 1);
  localparam logic [FCW-1:0] MAX_FRM  = FCW'(MAX_CHAIN);
  // crc8(16'h0000) is 8'h00 with a zero-initialised CRC
  localparam logic [FRAME_W-1:0] RESP_RST = '0;

  state_t             r_state, w_next;
  logic [FRAME_W-1:0] r_shift, r_resp;
  logic [BCW-1:0]     r_bit_cnt;
  logic [FCW-1:0]     r_frm_cnt;
  logic               r_frm_ovf, r_crc_err, r_len_err;
  logic [6:0]         r_addr;
  logic [7:0]         r_wdata;

  logic       w_sclk_rise, w_csb_rise, w_csb_fall, w_mosi_s;
  logic [7:0] w_rx_crc, w_resp_crc, w_status, w_resp_data;
  logic       w_len_ok, w_crc_ok;
  logic       w_miso, w_wr_en, w_rd_en, w_frm_done;

  spi_slv_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sclk     (bus.i_sclk),
    .i_csb      (bus.i_csb),
    .i_mosi     (bus.i_mosi),
    .o_sclk_rise(w_sclk_rise),
    .o_csb_rise (w_csb_rise),
    .o_csb_fall (w_csb_fall),
    .o_mosi_s   (w_mosi_s)
  );

  crc16to8_parallel u_rx_crc (
    .i_data(r_shift[FRAME_W-1:DATA_LSB]),
    .o_crc (w_rx_crc)
  );

  crc16to8_parallel u_resp_crc (
    .i_data({w_status, w_resp_data}),
    .o_crc (w_resp_crc)
  );

  assign w_len_ok = (r_bit_cnt == '0) && (r_frm_cnt != '0) &&
                    (r_frm_cnt <= MAX_FRM) && !r_frm_ovf;
  assign w_crc_ok = (w_rx_crc == r_shift[CRC_MSB:CRC_LSB]);

  // During CHECK the status reflects the verdict being taken, not the previous frame's
  always_comb begin
    w_status    = '0;
    w_resp_data = '0;
    if (r_state == CHECK) begin
      w_status[ST_CRC_BIT] = w_len_ok & ~w_crc_ok;
      w_status[ST_LEN_BIT] = ~w_len_ok;
    end else begin
      w_status[ST_CRC_BIT] = r_crc_err;
      w_status[ST_LEN_BIT] = r_len_err;
    end
    if (r_state == RESP) w_resp_data = bus.i_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_csb_fall) w_next = SHIFT;
      SHIFT:   if (w_csb_rise) w_next = CHECK;
      CHECK:   w_next = (w_len_ok && w_crc_ok) ? EXEC : IDLE;
      EXEC:    w_next = r_shift[RW_BIT] ? RESP : IDLE;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_miso     = 1'b0;
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_frm_done = 1'b0;
    unique case (r_state)
      SHIFT: w_miso = r_shift[FRAME_W-1];
      CHECK: w_frm_done = 1'b1;
      EXEC: begin
        w_wr_en = ~r_shift[RW_BIT];
        w_rd_en = r_shift[RW_BIT];
      end
      default: ;
    endcase
  end

  // Address and write data are loaded on entry to EXEC so they line up with the strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_resp    <= RESP_RST;
      r_bit_cnt <= '0;
      r_frm_cnt <= '0;
      r_frm_ovf <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_csb_fall) begin
          r_shift   <= r_resp;
          r_bit_cnt <= '0;
          r_frm_cnt <= '0;
          r_frm_ovf <= 1'b0;
        end
        SHIFT: if (w_sclk_rise) begin
          r_shift <= {r_shift[FRAME_W-2:0], w_mosi_s};
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt <= '0;
            if (r_frm_cnt == MAX_FRM) r_frm_ovf <= 1'b1;
            else                      r_frm_cnt <= r_frm_cnt + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          r_len_err <= ~w_len_ok;
          r_crc_err <= w_len_ok & ~w_crc_ok;
          if (w_len_ok && w_crc_ok) begin
            r_addr <= r_shift[ADDR_MSB:ADDR_LSB];
            if (!r_shift[RW_BIT]) r_wdata <= r_shift[DATA_MSB:DATA_LSB];
          end else begin
            r_resp <= {w_status, 8'h00, w_resp_crc};
          end
        end
        EXEC: if (!r_shift[RW_BIT]) r_resp <= {w_status, 8'h00, w_resp_crc};
        RESP: r_resp <= {w_status, bus.i_rdata, w_resp_crc};
        default: ;
      endcase
    end
  end

  assign bus.o_miso     = w_miso;
  assign bus.o_wr_en    = w_wr_en;
  assign bus.o_rd_en    = w_rd_en;
  assign bus.o_frm_done = w_frm_done;
  assign bus.o_addr     = r_addr;
  assign bus.o_wdata    = r_wdata;
  assign bus.o_crc_err  = r_crc_err;
  assign bus.o_len_err  = r_len_err;
endmodule
